// File: rtl/meteor_pkg.sv
// meteor_pkg: shared screen limits, FSM states and slot record for the meteor spawner
package meteor_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  typedef enum logic [1:0] {IDLE, UPDATE, SPAWN, DONE} state_t;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] xspd;
    logic [2:0] yspd;
    logic       dir;
    logic       active;
  } meteor_t;
endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: synchronises the frame clock level and emits a one-cycle tick per rising edge
module frame_tick_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_frame,
  output logic o_tick
);
  logic       r_s1, r_s2, r_s3, r_arm, r_tick;
  logic [1:0] r_vld;
  // r_arm only sets after a genuine low level is seen, so a level still high across reset release never ticks
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_vld  <= 2'b00;
      r_arm  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_s1   <= i_frame;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_vld  <= {r_vld[0], 1'b1};
      r_arm  <= r_arm | (r_vld[1] & ~r_s2);
      r_tick <= r_s2 & ~r_s3 & r_arm;
    end
  assign o_tick = r_tick;
endmodule

// File: rtl/meteor_spawner.sv
// meteor_spawner: per-frame meteor slot updater with periodic spawning into the lowest free slot
module meteor_spawner
  import meteor_pkg::*;
#(
  parameter int NUM_METEORS  = 4,
  parameter int SPAWN_PERIOD = 16
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           frame_Clk,
  input  logic                           enable,
  input  logic                           clear_all,
  input  logic [9:0]                     rand_pos,
  input  logic [2:0]                     rand_xspd,
  input  logic [2:0]                     rand_yspd,
  input  logic                           rand_sign,
  input  logic [$clog2(NUM_METEORS)-1:0] rd_idx,
  output logic [9:0]                     meteor_x,
  output logic [9:0]                     meteor_y,
  output logic                           meteor_active,
  output logic [NUM_METEORS-1:0]         active_mask,
  output logic                           busy,
  output logic                           frame_done
);
  localparam int IW = NUM_METEORS > 1 ? $clog2(NUM_METEORS) : 1;
  localparam int CW = SPAWN_PERIOD > 1 ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SPAWN_PERIOD - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_METEORS - 1);
  localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1);

  state_t            r_state, w_next;
  logic [IW-1:0]     r_idx, w_free;
  logic [CW-1:0]     r_cnt;
  meteor_t           r_slots [NUM_METEORS];
  meteor_t           w_cur, w_new, w_rd;
  logic signed [10:0] w_xn, w_yn;
  logic              w_tick, w_exit, w_found, w_attempt, r_busy, r_done;

  frame_tick_sync u_sync (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_frame (frame_Clk),
    .o_tick  (w_tick)
  );

  assign w_cur     = r_slots[r_idx];
  assign w_xn      = w_cur.dir ? $signed({1'b0, w_cur.x} - {8'd0, w_cur.xspd})
                               : $signed({1'b0, w_cur.x} + {8'd0, w_cur.xspd});
  assign w_yn      = $signed({1'b0, w_cur.y} + {8'd0, w_cur.yspd});
  assign w_exit    = (w_xn < 11'sd0) || (w_xn > X_MAX) || (w_yn > Y_MAX);
  assign w_attempt = (r_state == SPAWN) && (r_cnt == '0) && enable;
  assign w_new     = '{x: (rand_pos < 10'(SCREEN_W)) ? rand_pos : rand_pos - 10'(SCREEN_W),
                       y: 10'd0, xspd: rand_xspd,
                       yspd: (rand_yspd == 3'd0) ? 3'd1 : rand_yspd,
                       dir: rand_sign, active: 1'b1};

  // lowest-index inactive slot for a spawn attempt
  always_comb begin
    w_found = 1'b0;
    w_free  = '0;
    for (int i = NUM_METEORS - 1; i >= 0; i--)
      if (!r_slots[i].active) begin
        w_found = 1'b1;
        w_free  = IW'(i);
      end
  end

  // next-state logic; clear_all overrides everything including a pending tick
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_tick ? UPDATE : IDLE;
      UPDATE:  w_next = (r_idx == LAST) ? SPAWN : UPDATE;
      SPAWN:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (clear_all) w_next = IDLE;
  end

  // state register
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) r_state <= IDLE;
    else r_state <= w_next;

  // slot walker, spawn countdown and registered status flags
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_idx  <= '0;
      r_cnt  <= RELOAD;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_idx  <= (r_state == UPDATE && w_next == UPDATE) ? r_idx + 1'b1 : '0;
      r_cnt  <= clear_all ? RELOAD : (r_state != SPAWN) ? r_cnt : (r_cnt == '0) ? RELOAD : r_cnt - 1'b1;
      r_busy <= w_next != IDLE;
      r_done <= w_next == DONE;
    end

  // slot storage: clear, per-slot motion/exit during UPDATE, spawn fill during SPAWN
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      for (int i = 0; i < NUM_METEORS; i++) r_slots[i] <= '0;
    end else if (clear_all) begin
      for (int i = 0; i < NUM_METEORS; i++) r_slots[i].active <= 1'b0;
    end else if (r_state == UPDATE && w_cur.active) begin
      if (w_exit) r_slots[r_idx].active <= 1'b0;
      else begin
        r_slots[r_idx].x <= w_xn[9:0];
        r_slots[r_idx].y <= w_yn[9:0];
      end
    end else if (w_attempt && w_found) begin
      r_slots[w_free] <= w_new;
    end

  // per-slot active flags
  always_comb begin
    active_mask = '0;
    for (int i = 0; i < NUM_METEORS; i++) active_mask[i] = r_slots[i].active;
  end

  assign w_rd          = (int'(rd_idx) < NUM_METEORS) ? r_slots[rd_idx] : '0;
  assign meteor_x      = w_rd.x;
  assign meteor_y      = w_rd.y;
  assign meteor_active = w_rd.active;
  assign busy          = r_busy;
  assign frame_done    = r_done;
endmodule
